// File: rtl/raster_int_gen.sv
// Frame and raster-line /INT generator. Each pulse lasts INT_LEN CPU T-states.
// Define INT_ACK_CUT_EN to end an active pulse early on a Z80 interrupt acknowledge.
module raster_int_gen #(
  parameter logic [7:0] INT_LEN   = 8'd32,
  parameter logic [8:0] VRET_LINE = 9'd248,
  parameter logic [8:0] VRET_HC   = 9'd0,
  parameter logic [8:0] RASTER_HC = 9'd256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_ce,
  input  logic [8:0] hc,
  input  logic [8:0] vc,
  input  logic       rasterint_enable,
  input  logic       vretraceint_disable,
  input  logic [8:0] raster_line,
  input  logic       m1_n,
  input  logic       iorq_n,
  output logic       int_n,
  output logic       raster_int_in_progress
);

  typedef enum logic [1:0] {IDLE, VRET, RAST} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       vret_q, rast_q;
  logic       vret_m, rast_m;
  logic       vret_trig, rast_trig;
  logic       ack;

  assign vret_m    = (vc == VRET_LINE) && (hc == VRET_HC) && !vretraceint_disable;
  assign rast_m    = (vc == raster_line) && (hc == RASTER_HC) && rasterint_enable;
  assign vret_trig = vret_m && !vret_q;
  assign rast_trig = rast_m && !rast_q;

`ifdef INT_ACK_CUT_EN
  assign ack = !m1_n && !iorq_n;
`else
  logic unused_ack;
  assign unused_ack = m1_n ^ iorq_n;
  assign ack        = 1'b0;
`endif

  // Triggers are only accepted in IDLE, so events during a pulse are simply lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      int_n                  <= 1'b1;
      raster_int_in_progress <= 1'b0;
      cnt                    <= 8'd0;
      vret_q                 <= 1'b0;
      rast_q                 <= 1'b0;
    end else begin
      vret_q <= vret_m;
      rast_q <= rast_m;
      case (state)
        IDLE: begin
          if (rast_trig) begin
            state                  <= RAST;
            cnt                    <= INT_LEN;
            int_n                  <= 1'b0;
            raster_int_in_progress <= 1'b1;
          end else if (vret_trig) begin
            state <= VRET;
            cnt   <= INT_LEN;
            int_n <= 1'b0;
          end
        end
        VRET, RAST: begin
          if (ack || (cpu_ce && cnt == 8'd1)) begin
            state                  <= IDLE;
            cnt                    <= 8'd0;
            int_n                  <= 1'b1;
            raster_int_in_progress <= 1'b0;
          end else if (cpu_ce) begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state                  <= IDLE;
          int_n                  <= 1'b1;
          raster_int_in_progress <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raster_int_gen.sv
// Bench for raster_int_gen: vector table, directed pulse sequences and a random run
// against a strobe-counting reference model. dutB uses RASTER_HC=0 to collide with the frame point.
module tb_raster_int_gen;

`ifdef INT_ACK_CUT_EN
  localparam bit ACK_CUT = 1'b1;
`else
  localparam bit ACK_CUT = 1'b0;
`endif
  localparam int INT_LEN = 32;

  logic       clk, rst, cpu_ce, m1_n, iorq_n;
  logic [8:0] hc, vc, raster_line;
  logic       rasterint_enable, vretraceint_disable;
  logic       int_nA, ripA, int_nB, ripB;

  int compared = 0;
  int mismatched = 0;
  int ceDiv = 0;
  bit ceRandom = 0;
  int strA, strB, fallA, fallB, lowA, lowB, ripHiA, ripHiB;

  typedef struct packed {
    bit active;
    bit rast;
    int left;
    bit vq;
    bit rq;
  } modelT;
  modelT mA = '0, mB = '0;

  typedef struct {
    logic [8:0] vc, hc, rl;
    logic en, dis;
    logic intA, ripA, intB, ripB;
  } vecT;
  vecT vecs[11];

  raster_int_gen dut (
    .clk(clk), .rst(rst), .cpu_ce(cpu_ce), .hc(hc), .vc(vc),
    .rasterint_enable(rasterint_enable), .vretraceint_disable(vretraceint_disable),
    .raster_line(raster_line), .m1_n(m1_n), .iorq_n(iorq_n),
    .int_n(int_nA), .raster_int_in_progress(ripA)
  );

  raster_int_gen #(.RASTER_HC(9'd0)) dutB (
    .clk(clk), .rst(rst), .cpu_ce(cpu_ce), .hc(hc), .vc(vc),
    .rasterint_enable(rasterint_enable), .vretraceint_disable(vretraceint_disable),
    .raster_line(raster_line), .m1_n(m1_n), .iorq_n(iorq_n),
    .int_n(int_nB), .raster_int_in_progress(ripB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse = INT_LEN counted strobes after the trigger edge; raster wins ties.
  function automatic modelT modelStep(input modelT m, input logic [8:0] rhc);
    modelT n;
    bit vm, rm;
    n  = m;
    vm = (vc == 9'd248) && (hc == 9'd0) && !vretraceint_disable;
    rm = (vc == raster_line) && (hc == rhc) && rasterint_enable;
    if (rst) return '0;
    n.vq = vm;
    n.rq = rm;
    if (m.active) begin
      if (ACK_CUT && !m1_n && !iorq_n) begin
        n.active = 0; n.rast = 0; n.left = 0;
      end else if (cpu_ce) begin
        n.left = m.left - 1;
        if (n.left == 0) begin n.active = 0; n.rast = 0; end
      end
    end else if (rm && !m.rq) begin
      n.active = 1; n.rast = 1; n.left = INT_LEN;
    end else if (vm && !m.vq) begin
      n.active = 1; n.rast = 0; n.left = INT_LEN;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, wanted %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, wanted %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] v, input logic [8:0] h, input logic [8:0] r,
                               input logic e, input logic d);
    vc = v; hc = h; raster_line = r; rasterint_enable = e; vretraceint_disable = d;
  endtask

  task automatic tick();
    @(posedge clk);
    mA = modelStep(mA, 9'd256);
    mB = modelStep(mB, 9'd0);
    #1;
    checkOutput("model_int_nA", int_nA, !mA.active);
    checkOutput("model_ripA", ripA, mA.active && mA.rast);
    checkOutput("model_int_nB", int_nB, !mB.active);
    checkOutput("model_ripB", ripB, mB.active && mB.rast);
    ceDiv = (ceDiv + 1) % 8;
    cpu_ce = ceRandom ? ($urandom_range(0, 3) == 0) : (ceDiv == 0);
  endtask

  task automatic clearCounts();
    strA = 0; strB = 0; fallA = 0; fallB = 0; lowA = 0; lowB = 0; ripHiA = 0; ripHiB = 0;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      logic pa, pb;
      if (!int_nA && cpu_ce) strA++;
      if (!int_nB && cpu_ce) strB++;
      pa = int_nA;
      pb = int_nB;
      tick();
      if (pa && !int_nA) fallA++;
      if (pb && !int_nB) fallB++;
      if (!int_nA) lowA++;
      if (!int_nB) lowB++;
      if (ripA) ripHiA++;
      if (ripB) ripHiB++;
    end
  endtask

  task automatic doReset();
    applyStimulus(9'd300, 9'd300, 9'd100, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int s;
    bit hit, acked;
    rst = 1'b1; cpu_ce = 1'b0; m1_n = 1'b1; iorq_n = 1'b1;
    applyStimulus(9'd300, 9'd300, 9'd100, 1'b0, 1'b1);

    // vc, hc, raster_line, en, dis | int_nA, ripA, int_nB, ripB
    vecs[0]  = '{9'd248, 9'd0,   9'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{9'd248, 9'd0,   9'd100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{9'd100, 9'd256, 9'd100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{9'd100, 9'd256, 9'd100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{9'd101, 9'd256, 9'd100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{9'd248, 9'd1,   9'd100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{9'd248, 9'd256, 9'd248, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{9'd248, 9'd0,   9'd248, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{9'd248, 9'd0,   9'd248, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{9'd0,   9'd0,   9'd0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{9'd100, 9'd0,   9'd100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    tick();
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      doReset();
      checkOutput($sformatf("vec%0d_reset_int_n", i), int_nA, 1'b1);
      checkOutput($sformatf("vec%0d_reset_rip", i), ripA, 1'b0);
      applyStimulus(vecs[i].vc, vecs[i].hc, vecs[i].rl, vecs[i].en, vecs[i].dis);
      tick();
      checkOutput($sformatf("vec%0d_int_nA", i), int_nA, vecs[i].intA);
      checkOutput($sformatf("vec%0d_ripA", i), ripA, vecs[i].ripA);
      checkOutput($sformatf("vec%0d_int_nB", i), int_nB, vecs[i].intB);
      checkOutput($sformatf("vec%0d_ripB", i), ripB, vecs[i].ripB);
    end

    // Frame pulse with the match held for 8 clk
    doReset(); clearCounts();
    applyStimulus(9'd248, 9'd0, 9'd100, 1'b0, 1'b0);
    runCycles(8);
    hc = 9'd1;
    runCycles(300);
    checkInt("frame_strobes", strA, INT_LEN);
    checkInt("frame_pulses", fallA, 1);
    checkInt("frame_rip_cycles", ripHiA, 0);
    checkInt("frame_strobesB", strB, INT_LEN);

    // Raster pulse on line 100
    doReset(); clearCounts();
    applyStimulus(9'd100, 9'd256, 9'd100, 1'b1, 1'b0);
    runCycles(3);
    hc = 9'd257;
    runCycles(300);
    checkInt("raster_strobes", strA, INT_LEN);
    checkInt("raster_pulses", fallA, 1);
    checkInt("raster_rip_vs_low", ripHiA, lowA);
    checkInt("raster_pulsesB", fallB, 0);

    // Simultaneous frame and raster match (collides on dutB only)
    doReset(); clearCounts();
    applyStimulus(9'd248, 9'd0, 9'd248, 1'b1, 1'b0);
    runCycles(8);
    hc = 9'd1;
    runCycles(300);
    checkInt("simul_pulsesB", fallB, 1);
    checkInt("simul_strobesB", strB, INT_LEN);
    checkInt("simul_rip_vs_lowB", ripHiB, lowB);
    checkInt("simul_pulsesA", fallA, 1);
    checkInt("simul_ripA_cycles", ripHiA, 0);

    // Both sources masked across two scans of every line
    doReset(); clearCounts();
    applyStimulus(9'd0, 9'd0, 9'd511, 1'b0, 1'b1);
    for (int f = 0; f < 2; f++)
      for (int v = 0; v < 512; v++)
        for (int k = 0; k < 4; k++) begin
          vc = 9'(v);
          hc = (k == 0) ? 9'd0 : 9'(254 + k);
          runCycles(1);
        end
    checkInt("mask_low_cyclesA", lowA, 0);
    checkInt("mask_low_cyclesB", lowB, 0);

    // Reset on the 10th strobe of a raster pulse, then a fresh full pulse
    doReset();
    applyStimulus(9'd100, 9'd256, 9'd100, 1'b1, 1'b0);
    s = 0; hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (!int_nA && cpu_ce) s++;
      if (s == 10) begin rst = 1'b1; hit = 1; end
      tick();
      if (i == 2) hc = 9'd257;
    end
    rst = 1'b0;
    checkInt("rstmid_reached", int'(hit), 1);
    checkOutput("rstmid_int_n", int_nA, 1'b1);
    checkOutput("rstmid_rip", ripA, 1'b0);
    clearCounts();
    hc = 9'd256;
    runCycles(3);
    hc = 9'd257;
    runCycles(300);
    checkInt("rstmid_next_strobes", strA, INT_LEN);
    checkInt("rstmid_next_pulses", fallA, 1);

    // Interrupt acknowledge on the 5th strobe of a frame pulse
    doReset();
    applyStimulus(9'd248, 9'd0, 9'd100, 1'b0, 1'b0);
    s = 0; acked = 0;
    for (int i = 0; i < 400; i++) begin
      bit doAck;
      doAck = 0;
      if (!int_nA && cpu_ce) s++;
      if (s == 5 && !acked) begin m1_n = 1'b0; iorq_n = 1'b0; acked = 1; doAck = 1; end
      tick();
      m1_n = 1'b1; iorq_n = 1'b1;
      if (i == 1) hc = 9'd1;
      if (doAck) checkOutput("ack_int_n", int_nA, ACK_CUT);
    end
    checkInt("ack_strobes", s, ACK_CUT ? 5 : INT_LEN);

    // Random run against the reference model
    doReset();
    ceRandom = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0: raster_line = 9'd248;
          1: raster_line = 9'd100;
          default: raster_line = 9'($urandom_range(0, 511));
        endcase
        case ($urandom_range(0, 2))
          0: vc = 9'd248;
          1: vc = raster_line;
          default: vc = 9'($urandom_range(0, 511));
        endcase
        case ($urandom_range(0, 2))
          0: hc = 9'd0;
          1: hc = 9'd256;
          default: hc = 9'($urandom_range(0, 511));
        endcase
        rasterint_enable = ($urandom_range(0, 3) != 0);
        vretraceint_disable = ($urandom_range(0, 3) == 0);
      end
      m1_n = ($urandom_range(0, 15) != 0);
      iorq_n = m1_n ? 1'b1 : ($urandom_range(0, 1) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; m1_n = 1'b1; iorq_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
